// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the L1
// instruction-miss path and the L1 data miss/writeback path.
module l2_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int LINE_W  = 128,
   parameter bit D_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [LINE_W-1:0] mem_rdata
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              last_d_q, last_d_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
   logic              d_req;
   logic              grant_d;

   // last_d_q doubles as the side being served until the next grant
   assign d_req   = d_read | d_write;
   assign grant_d = d_req & (~i_read | ~last_d_q);

   always_comb begin
      state_d   = state_q;
      last_d_d  = last_d_q;
      mem_rd_d  = mem_rd_q;
      mem_wr_d  = mem_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (i_read | d_req) begin
               last_d_d = grant_d;
               if (grant_d) begin
                  state_d  = SERVE_D;
                  addr_d   = d_addr;
                  mem_wr_d = d_write;
                  mem_rd_d = ~d_write;
                  if (d_write) begin
                     wdata_d = d_wdata;
                  end
               end else begin
                  state_d  = SERVE_I;
                  addr_d   = i_addr;
                  mem_rd_d = 1'b1;
               end
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp) begin
               state_d  = RESP;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               if (mem_rd_q) begin
                  if (state_q == SERVE_D) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     i_rdata_d = mem_rdata;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         last_d_q  <= ~D_FIRST;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         mem_rd_q  <= mem_rd_d;
         mem_wr_q  <= mem_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign i_resp    = (state_q == RESP) & ~last_d_q;
   assign d_resp    = (state_q == RESP) &  last_d_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_read  = mem_rd_q;
   assign mem_write = mem_wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule
